// File: rtl/debounce_pulser.sv
// debounce_pulser
//   Conditions raw, asynchronous, bouncy button inputs for downstream logic.
//   Each channel goes through a two-flop synchroniser and then a debounce FSM
//   with a stability counter. The result is a clean level and a one-cycle
//   press pulse per channel.
//
// Ports
//   clk        system clock, all state updates on posedge
//   reset      asynchronous active-high reset
//   btn_in     raw button inputs, 1 = pressed (asynchronous)
//   btn_level  debounced level per channel (registered)
//   btn_pulse  one-cycle pulse on each accepted press (registered)
//
// Parameters
//   N                number of independent channels (>= 1)
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a change (>= 2)
//   CNT_W            stability counter width, derived from DEBOUNCE_CYCLES
//
// Debounce FSM (one per channel)
//   state     | meaning
//   RELEASED  | button accepted as released, level = 0
//   PRESS_CHK | s went high, counting stable high samples
//   PRESSED   | button accepted as pressed, level = 1
//   REL_CHK   | s went low, counting stable low samples, level still 1

module debounce_pulser #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_pulse
);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    // Terminal count: the FSM leaves the check state on this value, so the
    // counter can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     sync_1;
    logic [N-1:0]     sync_s;
    state_t           state     [N];
    state_t           state_nxt [N];
    logic [CNT_W-1:0] cnt       [N];
    logic [CNT_W-1:0] cnt_nxt   [N];
    logic [N-1:0]     level_nxt;
    logic [N-1:0]     pulse_nxt;

    // State register, including the synchroniser and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1    <= '0;
            sync_s    <= '0;
            btn_level <= '0;
            btn_pulse <= '0;
            for (int i = 0; i < N; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
        end else begin
            sync_1    <= btn_in;
            sync_s    <= sync_1;
            btn_level <= level_nxt;
            btn_pulse <= pulse_nxt;
            for (int i = 0; i < N; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                RELEASED: begin
                    if (sync_s[i]) begin
                        state_nxt[i] = PRESS_CHK;
                        cnt_nxt[i]   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!sync_s[i]) begin
                        state_nxt[i] = RELEASED;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = PRESSED;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync_s[i]) begin
                        state_nxt[i] = REL_CHK;
                        cnt_nxt[i]   = '0;
                    end
                end
                REL_CHK: begin
                    if (sync_s[i]) begin
                        state_nxt[i] = PRESSED;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = RELEASED;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_nxt[i] = RELEASED;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Output logic, computed from the upcoming state so the registered
    // outputs change on the same edge as the state transition.
    always_comb begin
        level_nxt = '0;
        pulse_nxt = '0;
        for (int i = 0; i < N; i++) begin
            level_nxt[i] = (state_nxt[i] == PRESSED) || (state_nxt[i] == REL_CHK);
            // Only a confirmed press raises the pulse; REL_CHK -> PRESSED does not.
            pulse_nxt[i] = (state[i] == PRESS_CHK) && (state_nxt[i] == PRESSED);
        end
    end

endmodule

// File: tb/tb_debounce_pulser.sv
module tb_debounce_pulser;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    int n_cmp = 0;
    int n_err = 0;

    debounce_pulser #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the synchronised input has
    // disagreed with it for D+1 consecutive samples; any agreeing sample
    // restarts the run. A 0->1 flip produces a one-cycle pulse.
    logic [N-1:0] m_s1, m_s, m_level, m_pulse;
    int           run [N];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s = '0; m_level = '0; m_pulse = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            m_pulse = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s[i] != m_level[i]) run[i] = run[i] + 1;
                else                      run[i] = 0;
                if (run[i] == D + 1) begin
                    m_level[i] = ~m_level[i];
                    m_pulse[i] = m_level[i];
                    run[i]     = 0;
                end
            end
            m_s  = m_s1;
            m_s1 = btn_in;
        end
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive input away from the edge, clock, compare at negedge.
    task automatic cyc(input logic [N-1:0] v);
        btn_in = v;
        @(posedge clk);
        @(negedge clk);
        chk("model_level", btn_level, m_level);
        chk("model_pulse", btn_pulse, m_pulse);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_level", btn_level, '0);
        chk("rst_pulse", btn_pulse, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [N-1:0] cur;
    int           hold [N];

    initial begin
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 4; k++) cyc('0);

        // Clean press on channel 0.
        for (int k = 1; k <= 6; k++) cyc(4'b0001);
        chk("press_pre", btn_pulse, 4'b0000);
        cyc(4'b0001);
        chk("press_pulse", btn_pulse, 4'b0001);
        chk("press_level", btn_level, 4'b0001);
        cyc(4'b0001);
        chk("press_pulse_once", btn_pulse, 4'b0000);
        for (int k = 0; k < 12; k++) cyc(4'b0001);
        chk("held_level", btn_level, 4'b0001);
        for (int k = 1; k <= 6; k++) cyc(4'b0000);
        chk("release_pre", btn_level, 4'b0001);
        cyc(4'b0000);
        chk("release_level", btn_level, 4'b0000);
        chk("release_nopulse", btn_pulse, 4'b0000);

        // Bounce on channel 1, then stable high.
        for (int k = 0; k < 8; k++) begin
            cyc((k % 2 == 0) ? 4'b0010 : 4'b0000);
            chk("bounce_nopulse", btn_pulse, 4'b0000);
        end
        for (int k = 1; k <= 6; k++) cyc(4'b0010);
        chk("bounce_pre", btn_pulse, 4'b0000);
        cyc(4'b0010);
        chk("bounce_pulse", btn_pulse, 4'b0010);
        for (int k = 0; k < 8; k++) cyc(4'b0000);

        // Short glitch on channel 2.
        for (int k = 0; k < 3; k++) cyc(4'b0100);
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0000);
            chk("glitch_level", btn_level, 4'b0000);
        end

        // Release bounce on channel 3.
        for (int k = 0; k < 8; k++) cyc(4'b1000);
        chk("ch3_level", btn_level, 4'b1000);
        cyc(4'b0000);
        cyc(4'b0000);
        for (int k = 0; k < 10; k++) begin
            cyc(4'b1000);
            chk("relbounce_level", btn_level, 4'b1000);
            chk("relbounce_pulse", btn_pulse, 4'b0000);
        end
        for (int k = 0; k < 8; k++) cyc(4'b0000);

        // Simultaneous press on all channels.
        for (int k = 1; k <= 6; k++) cyc(4'b1111);
        cyc(4'b1111);
        chk("simul_pulse", btn_pulse, 4'b1111);
        for (int k = 0; k < 8; k++) cyc(4'b0000);
        chk("simul_released", btn_level, 4'b0000);

        // Reset during the count of a second press discards the partial count.
        for (int k = 0; k < 4; k++) cyc(4'b1111);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0000);
            chk("rst_abort_pulse", btn_pulse, 4'b0000);
        end
        for (int k = 1; k <= 6; k++) cyc(4'b1111);
        chk("restart_pre", btn_level, 4'b0000);
        cyc(4'b1111);
        chk("restart_pulse", btn_pulse, 4'b1111);

        // Reset while levels are high and btn_in held at F.
        for (int k = 0; k < 4; k++) cyc(4'b1111);
        do_reset();
        for (int k = 1; k <= 6; k++) cyc(4'b1111);
        cyc(4'b1111);
        chk("post_rst_level", btn_level, 4'b1111);

        // Randomised hold lengths per channel, checked against the model.
        cur = '0;
        for (int i = 0; i < N; i++) hold[i] = 1;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    cur[i]  = ~cur[i];
                    hold[i] = int'($urandom_range(1, 2 * D + 4));
                end
            end
            cyc(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_pulser.md
Name: debounce_pulser

Overview:
- Input conditioning stage that sits directly upstream of the lab's D flip-flop, register and counter stages.
- Takes raw, asynchronous, bouncy push-button or switch inputs and synchronises them to clk.
- Debounces each channel independently with a stability counter.
- Produces a clean level output and a single-cycle press pulse per channel, suitable for driving d or clock-enable inputs downstream.

Parameters:
- N, 4: number of independent button channels (N >= 1).
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a change (>= 2; smaller values are a configuration error).
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of each channel's stability counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-high reset (asserts immediately, releases synchronously to clk by the system).
- btn_in  input  N  raw asynchronous button inputs, 1 = pressed.
- btn_level  output  N  debounced level per channel, registered.
- btn_pulse  output  N  one-cycle pulse per channel on each accepted press (0->1 of btn_level), registered.

Behaviour:
- Reset (async, active-high): all synchroniser flops = 0, every channel FSM = RELEASED, counters = 0, btn_level = 0, btn_pulse = 0. Applies immediately, mid-count included; any partial count is discarded.
- Synchroniser: two flops per channel, btn_in -> s1 -> s. The FSM sees only s. Synchroniser latency is 2 edges.
- Per-channel FSM, evaluated on every edge:
  - RELEASED: btn_level = 0. If s = 1, go to PRESS_CHK with cnt = 0. Otherwise stay.
  - PRESS_CHK: if s = 0, go to RELEASED (glitch rejected, no pulse). Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED. Else cnt = cnt + 1.
  - PRESSED: btn_level = 1. If s = 0, go to REL_CHK with cnt = 0.
  - REL_CHK: btn_level stays 1. If s = 1, go to PRESSED (no new pulse). Else if cnt == DEBOUNCE_CYCLES-1, go to RELEASED and btn_level = 0. Else cnt = cnt + 1.
- btn_level: registered. Updates on the same edge as the transition into PRESSED or into RELEASED.
- btn_pulse[i]: registered. Equals 1 for exactly the one cycle following the edge on which channel i enters PRESSED from PRESS_CHK. Otherwise 0. Never asserted on release. Never asserted on REL_CHK -> PRESSED.
- Latency: btn_in[i] first sampled high at edge E and held high. Then btn_level[i] and btn_pulse[i] go high after edge E + DEBOUNCE_CYCLES + 2. Release latency is symmetric for btn_level.
- Glitch filtering: a high (or low) excursion of s shorter than DEBOUNCE_CYCLES+1 consecutive samples produces no output change.
- Counter never wraps: it saturates at DEBOUNCE_CYCLES-1 by construction, because the FSM leaves the check state on that edge.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses, with no arbitration.
- Held button: btn_level stays 1 indefinitely, and only one pulse is issued per accepted press.
- Outputs are glitch-free, since all are flop outputs with no combinational path from btn_in.

Test Plan:
- Reset: assert reset mid-simulation with btn_in = 4'hF -> btn_level = 0 and btn_pulse = 0 immediately (before the next clk edge). After release with btn_in held at 4'hF, btn_level = 4'hF after 6 edges.
- Clean press, N=4, D=4: btn_in[0] rises before edge 0 and is held 20 cycles -> btn_pulse = 4'b0001 for exactly the one cycle after edge 6, btn_level[0] = 1 from edge 6 on. Release -> btn_level[0] = 0 after 6 edges, no pulse.
- Bounce rejection: btn_in[1] toggles 1,0,1,0 every cycle for 8 cycles, then holds 1 -> no pulse during bounce, exactly one pulse 6 edges after the final stable rise.
- Short glitch: btn_in[2] high for 3 cycles, then low -> btn_level[2] and btn_pulse[2] stay 0 throughout.
- Release bounce: with btn_level[3] = 1, btn_in[3] drops low for 2 cycles then returns high -> btn_level[3] stays 1, no second pulse.
- Simultaneous: btn_in rises 4'b0000 -> 4'b1111 on one cycle -> btn_pulse = 4'b1111 for one cycle after edge 6. Reset asserted at edge 4 of a second press -> no pulse, and state restarts from RELEASED.
